// File: rtl/stack_multi_seq.sv
// Expands a Thumb PUSH/POP register list into sequential word accesses, then commits the new SP.
// Latency: n access cycles (each at least 1 cycle) plus one SP-update cycle; an empty list takes one cycle.
// Backpressure: mem_ack=0 holds the current access stable indefinitely; start is ignored while busy.
module stack_multi_seq #(
  parameter int ADDR_W     = 32,
  parameter int WORD_BYTES = 4
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              start,
  input  logic              is_push,
  input  logic [7:0]        reg_list,
  input  logic              r_bit,
  input  logic [ADDR_W-1:0] sp_in,
  input  logic              mem_ack,
  output logic              busy,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [3:0]        reg_idx,
  output logic              reg_we,
  output logic              sp_we,
  output logic [ADDR_W-1:0] sp_out,
  output logic              done
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_XFER  = 2'd1,
    ST_SPUPD = 2'd2
  } state_t;

  localparam logic [ADDR_W-1:0] STRIDE = ADDR_W'(WORD_BYTES);

  state_t            state_q, state_d;
  logic              is_push_q;
  logic [8:0]        list_q;
  logic [ADDR_W-1:0] cur_q;
  logic [ADDR_W-1:0] sp_new_q;
  logic              sp_upd_q;

  logic [8:0]        list_in;
  logic [3:0]        n_in;
  logic [ADDR_W-1:0] span_in;
  logic [ADDR_W-1:0] base_in;
  logic [3:0]        low_entry;
  logic              last_entry;
  logic              launch;
  logic              xfer_done;

  assign list_in = {r_bit, reg_list};
  assign launch  = (state_q == ST_IDLE) && start;

  // Count the registers selected by the incoming instruction.
  always_comb begin
    n_in = 4'd0;
    for (int i = 0; i < 9; i++) begin
      n_in = n_in + 4'(list_in[i]);
    end
  end

  // PUSH pre-decrements the whole block; POP starts at the current SP.
  assign span_in = ADDR_W'(n_in) * STRIDE;
  assign base_in = is_push ? (sp_in - span_in) : sp_in;

  // Lowest remaining entry is serviced first so registers ascend with address.
  always_comb begin
    low_entry = 4'd0;
    for (int i = 8; i >= 0; i--) begin
      if (list_q[i]) begin
        low_entry = 4'(i);
      end
    end
  end

  // Exactly one bit left means the current access is the final one.
  assign last_entry = ((list_q & (list_q - 9'd1)) == 9'd0);
  assign xfer_done  = (state_q == ST_XFER) && mem_ack && last_entry;

  // State register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state selection: launch, walk the list, one SP-update cycle, back to idle.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d = (n_in != 4'd0) ? ST_XFER : ST_SPUPD;
        end
      end
      ST_XFER: begin
        if (xfer_done) begin
          state_d = ST_SPUPD;
        end
      end
      ST_SPUPD: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Operation context: latched on launch, list and address advanced on each accepted access.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      is_push_q <= 1'b0;
      list_q    <= 9'd0;
      cur_q     <= '0;
      sp_new_q  <= '0;
      sp_upd_q  <= 1'b0;
    end else if (launch) begin
      is_push_q <= is_push;
      list_q    <= list_in;
      cur_q     <= base_in;
      sp_new_q  <= is_push ? base_in : (sp_in + span_in);
      sp_upd_q  <= (n_in != 4'd0);
    end else if ((state_q == ST_XFER) && mem_ack) begin
      list_q <= list_q & (list_q - 9'd1);
      cur_q  <= cur_q + STRIDE;
    end
  end

  // Outputs are decoded from state so everything reads zero in idle and under reset.
  assign busy     = (state_q != ST_IDLE);
  assign mem_req  = (state_q == ST_XFER);
  assign mem_we   = mem_req && is_push_q;
  assign mem_addr = mem_req ? cur_q : '0;
  assign reg_idx  = !mem_req         ? 4'd0 :
                    !low_entry[3]    ? low_entry :
                    is_push_q        ? 4'd14 : 4'd15;
  assign reg_we   = mem_req && mem_ack && !is_push_q;
  assign done     = (state_q == ST_SPUPD);
  assign sp_we    = done && sp_upd_q;
  assign sp_out   = sp_we ? sp_new_q : '0;

endmodule

// File: tb/tb_stack_multi_seq.sv
module tb_stack_multi_seq;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        start;
  logic        is_push;
  logic [7:0]  reg_list;
  logic        r_bit;
  logic [31:0] sp_in;
  logic        mem_ack;
  logic        busy;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [3:0]  reg_idx;
  logic        reg_we;
  logic        sp_we;
  logic [31:0] sp_out;
  logic        done;

  int checks = 0;
  int errors = 0;

  stack_multi_seq #(.ADDR_W(32), .WORD_BYTES(4)) dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .start    (start),
    .is_push  (is_push),
    .reg_list (reg_list),
    .r_bit    (r_bit),
    .sp_in    (sp_in),
    .mem_ack  (mem_ack),
    .busy     (busy),
    .mem_req  (mem_req),
    .mem_we   (mem_we),
    .mem_addr (mem_addr),
    .reg_idx  (reg_idx),
    .reg_we   (reg_we),
    .sp_we    (sp_we),
    .sp_out   (sp_out),
    .done     (done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_idle_outputs(input string tag);
    chk({tag, " busy"}, 32'(busy), 32'd0);
    chk({tag, " mem_req"}, 32'(mem_req), 32'd0);
    chk({tag, " mem_we"}, 32'(mem_we), 32'd0);
    chk({tag, " mem_addr"}, mem_addr, 32'd0);
    chk({tag, " reg_idx"}, 32'(reg_idx), 32'd0);
    chk({tag, " reg_we"}, 32'(reg_we), 32'd0);
    chk({tag, " sp_we"}, 32'(sp_we), 32'd0);
    chk({tag, " sp_out"}, sp_out, 32'd0);
    chk({tag, " done"}, 32'(done), 32'd0);
  endtask

  // mode 0: ack always 1; mode 1: random ack; mode 2: ack low 3 cycles on 2nd access.
  // abort: pull reset during the 2nd access and return early.
  task automatic run_op(input bit push, input logic [7:0] rl, input bit rb,
                        input logic [31:0] sp, input int mode, input bit abort,
                        output logic [31:0] sp_seen, output int done_cyc);
    int          regs[$];
    int          n;
    int          idx;
    int          cyc;
    int          low_cnt;
    bit          fin;
    bit          ack;
    logic [31:0] base;
    logic [31:0] new_sp;
    logic [8:0]  full;

    full = {rb, rl};
    regs.delete();
    for (int k = 0; k < 9; k++) begin
      if (full[k]) regs.push_back(k < 8 ? k : (push ? 14 : 15));
    end
    n      = regs.size();
    base   = push ? sp - 32'(4 * n) : sp;
    new_sp = push ? base : sp + 32'(4 * n);
    idx = 0; cyc = 0; low_cnt = 0; fin = 0;
    sp_seen = 32'd0; done_cyc = -1;

    @(negedge clk);
    is_push = push; reg_list = rl; r_bit = rb; sp_in = sp; start = 1'b1; mem_ack = 1'b0;
    @(negedge clk);
    while (!fin && cyc < 200) begin
      cyc++;
      start    = ($urandom_range(0, 3) == 0);
      is_push  = 1'($urandom);
      reg_list = 8'($urandom);
      r_bit    = 1'($urandom);
      sp_in    = $urandom;
      if (idx < n) begin
        if (abort && idx == 1) begin
          reset_n = 1'b0;
          #1;
          chk_idle_outputs("abort");
          start = 1'b0;
          @(negedge clk);
          reset_n = 1'b1;
          #1;
          chk_idle_outputs("post_abort");
          return;
        end
        case (mode)
          0:       ack = 1'b1;
          1:       ack = 1'($urandom_range(0, 1));
          default: ack = !(idx == 1 && low_cnt < 3);
        endcase
        if (!ack) low_cnt++;
        mem_ack = ack;
        #1;
        chk("xfer busy", 32'(busy), 32'd1);
        chk("xfer mem_req", 32'(mem_req), 32'd1);
        chk("xfer mem_we", 32'(mem_we), 32'(push));
        chk("xfer mem_addr", mem_addr, base + 32'(4 * idx));
        chk("xfer reg_idx", 32'(reg_idx), 32'(regs[idx]));
        chk("xfer reg_we", 32'(reg_we), 32'(ack && !push));
        chk("xfer done", 32'(done), 32'd0);
        chk("xfer sp_we", 32'(sp_we), 32'd0);
        if (ack) idx++;
      end else begin
        mem_ack = 1'($urandom);
        #1;
        chk("spupd busy", 32'(busy), 32'd1);
        chk("spupd mem_req", 32'(mem_req), 32'd0);
        chk("spupd done", 32'(done), 32'd1);
        chk("spupd sp_we", 32'(sp_we), 32'(n != 0));
        if (n != 0) chk("spupd sp_out", sp_out, new_sp);
        sp_seen  = sp_out;
        done_cyc = cyc;
        fin      = 1'b1;
      end
      @(negedge clk);
    end
    chk("op finished in budget", 32'(fin), 32'd1);
    start = 1'b0; mem_ack = 1'b0;
    #1;
    chk("back idle busy", 32'(busy), 32'd0);
    chk("back idle done", 32'(done), 32'd0);
  endtask

  logic [31:0] sp_res;
  int          dcyc;

  initial begin
    reset_n = 1'b0; start = 1'b0; is_push = 1'b0; reg_list = 8'd0; r_bit = 1'b0;
    sp_in = 32'd0; mem_ack = 1'b0;
    #12;
    chk_idle_outputs("reset");
    @(negedge clk);
    reset_n = 1'b1;

    // Case 1: PUSH {R0,R2,LR}
    run_op(1'b1, 8'h05, 1'b1, 32'h1000, 0, 1'b0, sp_res, dcyc);
    chk("case1 sp_out", sp_res, 32'h0FF4);
    chk("case1 done cycle", 32'(dcyc), 32'd4);

    // Case 2: POP {R1,PC}
    run_op(1'b0, 8'h02, 1'b1, 32'h0FF8, 0, 1'b0, sp_res, dcyc);
    chk("case2 sp_out", sp_res, 32'h1000);
    chk("case2 done cycle", 32'(dcyc), 32'd3);

    // Case 3: wait states on the second access
    run_op(1'b1, 8'h05, 1'b1, 32'h1000, 2, 1'b0, sp_res, dcyc);
    chk("case3 sp_out", sp_res, 32'h0FF4);
    chk("case3 done cycle", 32'(dcyc), 32'd7);

    // Case 4: empty list
    run_op(1'b1, 8'h00, 1'b0, 32'h2000, 0, 1'b0, sp_res, dcyc);
    chk("case4 sp_out", sp_res, 32'h0);
    chk("case4 done cycle", 32'(dcyc), 32'd1);
    run_op(1'b0, 8'h00, 1'b0, 32'h2000, 1, 1'b0, sp_res, dcyc);
    chk("case4 pop done cycle", 32'(dcyc), 32'd1);

    // Case 5: address wrap through zero
    run_op(1'b1, 8'h07, 1'b0, 32'h4, 0, 1'b0, sp_res, dcyc);
    chk("case5 sp_out", sp_res, 32'hFFFF_FFF8);
    run_op(1'b0, 8'h07, 1'b0, 32'hFFFF_FFF8, 1, 1'b0, sp_res, dcyc);
    chk("case5 pop sp_out", sp_res, 32'h4);

    // Case 6: reset mid-operation, then a clean rerun
    run_op(1'b1, 8'h05, 1'b1, 32'h1000, 0, 1'b1, sp_res, dcyc);
    run_op(1'b1, 8'h05, 1'b1, 32'h1000, 0, 1'b0, sp_res, dcyc);
    chk("case6 rerun sp_out", sp_res, 32'h0FF4);
    chk("case6 rerun done cycle", 32'(dcyc), 32'd4);

    // Full list both directions
    run_op(1'b1, 8'hFF, 1'b1, 32'h8000, 1, 1'b0, sp_res, dcyc);
    chk("full push sp_out", sp_res, 32'h7FDC);
    run_op(1'b0, 8'hFF, 1'b1, 32'h7FDC, 1, 1'b0, sp_res, dcyc);
    chk("full pop sp_out", sp_res, 32'h8000);

    // Randomized operations against the model
    for (int t = 0; t < 60; t++) begin
      run_op(1'($urandom), 8'($urandom), 1'($urandom), $urandom, 1, 1'b0, sp_res, dcyc);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
